// File: rtl/wb_pkg.sv
// Shared ISA constants and decode helpers for the W-stage write logic.
package wb_pkg;

    localparam logic [4:0] OP_R      = 5'b00000;
    localparam logic [4:0] OP_ADDI   = 5'b00101;
    localparam logic [4:0] OP_LW     = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b00011;
    localparam logic [4:0] OP_SETX   = 5'b10101;
    localparam logic [4:0] OP_CUSTOM = 5'b01100;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // mul/div results come back through the tag FIFO, never at W.
    function automatic logic is_pipe_write(input logic [31:0] insn);
        logic [4:0] op;
        logic [4:0] alu;
        op  = insn[31:27];
        alu = insn[6:2];
        case (op)
            OP_R:                                     return (alu != ALU_MUL) && (alu != ALU_DIV);
            OP_ADDI, OP_LW, OP_JAL, OP_SETX, OP_CUSTOM: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_tag_fifo.sv
// Circular FIFO of pending multdiv destinations; each entry can be killed by a younger
// in-order write to the same register.
module md_tag_fifo #(
    parameter int MD_DEPTH = 2,
    parameter int REG_AW   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic              pop,
    input  logic              kill,
    input  logic [REG_AW-1:0] kill_rd,
    output logic [REG_AW-1:0] head_rd,
    output logic              head_live,
    output logic              full,
    output logic              error
);

    localparam int PW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int CW = $clog2(MD_DEPTH + 1);

    logic [REG_AW-1:0]   rd_mem [MD_DEPTH];
    logic [MD_DEPTH-1:0] live_mem;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic                empty;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MD_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(MD_DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot, so push+pop is legal when full.
    assign do_push   = push & (~full | do_pop);
    assign head_rd   = rd_mem[rd_ptr];
    assign head_live = live_mem[rd_ptr] & ~empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            live_mem <= '0;
            error    <= 1'b0;
            for (int i = 0; i < MD_DEPTH; i++) rd_mem[i] <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < MD_DEPTH; i++) begin
                    if (rd_mem[i] == kill_rd) live_mem[i] <= 1'b0;
                end
            end
            // Written after the kill loop so a same-cycle push stays live.
            if (do_push) begin
                rd_mem[wr_ptr]   <= push_rd;
                live_mem[wr_ptr] <= 1'b1;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((push & ~do_push) | (pop & empty)) error <= 1'b1;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Regfile write-port arbiter: multdiv completions win over in-order W results,
// which are stalled and retried. Outputs are registered.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int MD_DEPTH   = 2,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [31:0]       insn_in,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic              write_exception,
    input  logic              md_issue,
    input  logic [REG_AW-1:0] md_issue_rd,
    input  logic              md_rdy,
    input  logic [DATA_W-1:0] md_result,
    output logic              ctrl_writeEnable,
    output logic [REG_AW-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              wb_stall,
    output logic              md_full,
    output logic              md_error
);

    logic [4:0]        opcode;
    logic              pw;
    logic              cw;
    logic              accept_pw;
    logic [REG_AW-1:0] pw_rd;
    logic [DATA_W-1:0] pw_data;
    logic [REG_AW-1:0] head_rd;
    logic              head_live;
    logic              unused_insn;

    assign opcode      = insn_in[31:27];
    assign unused_insn = ^{insn_in[21:7], insn_in[1:0]};

    assign pw = wb_valid & is_pipe_write(insn_in);

    always_comb begin
        pw_rd = REG_AW'(insn_in[26:22]);
        if (opcode == OP_JAL)                            pw_rd = REG_AW'(LINK_REG);
        else if ((opcode == OP_SETX) || write_exception) pw_rd = REG_AW'(STATUS_REG);
    end

    assign pw_data   = (opcode == OP_LW) ? d_in : o_in;
    assign cw        = md_rdy & head_live;
    assign wb_stall  = pw & cw;
    assign accept_pw = pw & ~cw;

    md_tag_fifo #(
        .MD_DEPTH (MD_DEPTH),
        .REG_AW   (REG_AW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (md_issue),
        .push_rd   (md_issue_rd),
        .pop       (md_rdy),
        .kill      (accept_pw & (pw_rd != '0)),
        .kill_rd   (pw_rd),
        .head_rd   (head_rd),
        .head_live (head_live),
        .full      (md_full),
        .error     (md_error)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else if (cw) begin
            ctrl_writeEnable <= (head_rd != '0);
            ctrl_writeReg    <= head_rd;
            data_writeReg    <= md_result;
        end else if (pw) begin
            ctrl_writeEnable <= (pw_rd != '0);
            ctrl_writeReg    <= pw_rd;
            data_writeReg    <= pw_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

endmodule
